// File: rtl/a5_pkg.sv
// a5_pkg -- shared constants and types for the A5/1 burst generator.
//   R1/R2/R3 : register lengths, feedback tap masks and clocking-bit indices
//   KEY_W / FRAME_W : session key and frame number widths
//   state_t  : controller state encoding
package a5_pkg;

  localparam int KEY_W       = 64;
  localparam int FRAME_W     = 22;
  localparam int LOAD_CYCLES = KEY_W + FRAME_W;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  // Feedback taps as bit masks: R1 18/17/16/13, R2 21/20, R3 22/21/20/7.
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MIX  = 3'd2,
    GEN  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/a5_burst_generator_if.sv
// a5_burst_generator_if -- keystream word stream (valid/ready).
//   out_valid : out_data/out_last/out_dir hold a word
//   out_ready : consumer accepts the word
//   out_data  : keystream word, first bit in the MSB
//   out_last  : final word of a burst
//   out_dir   : 0 = downlink burst, 1 = uplink burst
//   master = generator side, slave = consumer side
interface a5_burst_generator_if #(
  parameter int WORD_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_dir;

  modport master (output out_valid, output out_data, output out_last,
                  output out_dir, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last,
                  input out_dir, output out_ready);
endinterface

// File: rtl/a5_lfsr.sv
// a5_lfsr -- one A5/1 shift register.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (new session), wins over clk_en
//   clk_en       : step the register this cycle
//   din          : bit XORed into the feedback (key/frame loading)
//   msb          : MSB the register will hold after this cycle's step
//   clk_bit      : current value of the majority clocking bit
module a5_lfsr
  import a5_pkg::*;
#(
  parameter int              LEN     = R1_LEN,
  parameter logic [LEN-1:0]  TAPS    = R1_TAPS,
  parameter int              CLK_BIT = R1_CLK
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic clk_en,
  input  logic din,
  output logic msb,
  output logic clk_bit
);

  logic [LEN-1:0] r_state;
  logic           w_fb;

  assign w_fb = (^(r_state & TAPS)) ^ din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
    end else if (clr) begin
      r_state <= '0;
    end else if (clk_en) begin
      r_state <= {r_state[LEN-2:0], w_fb};
    end
  end

  assign clk_bit = r_state[CLK_BIT];
  // Keystream is taken after the step, so expose the post-step MSB.
  assign msb = clk_en ? r_state[LEN-2] : r_state[LEN-1];

endmodule

// File: rtl/a5_burst_generator.sv
// a5_burst_generator -- A5/1 keystream generator producing one downlink and
// one uplink burst per session, packed MSB-first into WORD_W-bit words.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle session request (restarts from any state)
//   key, frame   : session key / frame number, bit 0 loaded first
//   busy         : session in progress
//   out_if       : keystream word stream (master side)
module a5_burst_generator
  import a5_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int BURST_BITS = 114,
  parameter int MIX_CYCLES = 100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  a5_burst_generator_if.master out_if
);

  localparam int CNT_MAX = (LOAD_CYCLES > MIX_CYCLES) ? LOAD_CYCLES : MIX_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = (BURST_BITS > 1) ? $clog2(BURST_BITS) : 1;
  localparam int PCNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t                   r_state, w_state_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [BIT_W-1:0]         r_bit;
  logic [PCNT_W-1:0]        r_pcnt;
  logic [WORD_W-1:0]        r_pack;
  logic [LOAD_CYCLES-1:0]   r_ld;
  logic                     r_dir, r_gen_end;
  logic                     r_valid, r_last, r_odir;
  logic [WORD_W-1:0]        r_data;

  logic [2:0]               w_en, w_msb, w_cbit;
  logic                     w_maj, w_load, w_step_maj, w_din, w_ks;
  logic                     w_wdone, w_stall, w_gen_step, w_burst_end;
  logic [PCNT_W-1:0]        w_bit_pos;
  logic [WORD_W-1:0]        w_word;

  // ---------------- shift registers ----------------
  a5_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(clk), .reset_n(reset_n), .clr(start), .clk_en(w_en[0]),
    .din(w_din), .msb(w_msb[0]), .clk_bit(w_cbit[0]));
  a5_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(clk), .reset_n(reset_n), .clr(start), .clk_en(w_en[1]),
    .din(w_din), .msb(w_msb[1]), .clk_bit(w_cbit[1]));
  a5_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(clk), .reset_n(reset_n), .clr(start), .clk_en(w_en[2]),
    .din(w_din), .msb(w_msb[2]), .clk_bit(w_cbit[2]));

  assign w_maj  = (w_cbit[0] & w_cbit[1]) | (w_cbit[0] & w_cbit[2]) |
                  (w_cbit[1] & w_cbit[2]);
  assign w_load = (r_state == LOAD);
  assign w_din  = w_load ? r_ld[0] : 1'b0;

  // A word completes on a full packer or on the last bit of a burst; it can
  // only leave if the output register is free this cycle, else everything
  // holds so no bit is lost.
  assign w_burst_end = (r_bit == BIT_W'(BURST_BITS - 1));
  assign w_wdone     = (r_pcnt == PCNT_W'(WORD_W - 1)) || w_burst_end;
  assign w_stall     = w_wdone && r_valid && !out_if.out_ready;
  assign w_gen_step  = (r_state == GEN) && !r_gen_end && !w_stall;
  assign w_step_maj  = (r_state == MIX) || w_gen_step;

  for (genvar gi = 0; gi < 3; gi++) begin : g_en
    assign w_en[gi] = w_load || (w_step_maj && (w_cbit[gi] == w_maj));
  end

  assign w_ks      = ^w_msb;
  assign w_bit_pos = PCNT_W'(WORD_W - 1) - r_pcnt;
  // Unfilled low bits of r_pack stay zero, which pads a short final word.
  assign w_word    = r_pack | (WORD_W'(w_ks) << w_bit_pos);

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    if (start) begin
      w_state_next = LOAD;
    end else begin
      case (r_state)
        IDLE: w_state_next = IDLE;
        LOAD: if (r_cnt == CNT_W'(LOAD_CYCLES - 1)) w_state_next = MIX;
        MIX:  if (r_cnt == CNT_W'(MIX_CYCLES - 1))  w_state_next = GEN;
        GEN:  if (r_gen_end && r_valid && out_if.out_ready) w_state_next = DONE;
        DONE: w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // ---------------- counters, packer, output register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_pcnt    <= '0;
      r_pack    <= '0;
      r_ld      <= '0;
      r_dir     <= 1'b0;
      r_gen_end <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_odir    <= 1'b0;
      r_data    <= '0;
    end else if (start) begin
      // Restart drops any word in flight; data/last/dir are masked by valid.
      r_cnt     <= '0;
      r_bit     <= '0;
      r_pcnt    <= '0;
      r_pack    <= '0;
      r_ld      <= {frame, key};
      r_dir     <= 1'b0;
      r_gen_end <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      if (r_valid && out_if.out_ready) r_valid <= 1'b0;
      case (r_state)
        LOAD: begin
          r_ld  <= r_ld >> 1;
          r_cnt <= (r_cnt == CNT_W'(LOAD_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
        end
        MIX: r_cnt <= r_cnt + 1'b1;
        GEN: begin
          if (w_gen_step) begin
            if (w_wdone) begin
              r_valid <= 1'b1;
              r_data  <= w_word;
              r_last  <= w_burst_end;
              r_odir  <= r_dir;
              r_pack  <= '0;
              r_pcnt  <= '0;
            end else begin
              r_pack  <= w_word;
              r_pcnt  <= r_pcnt + 1'b1;
            end
            if (w_burst_end) begin
              r_bit <= '0;
              if (r_dir) r_gen_end <= 1'b1;
              else       r_dir     <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_data;
  assign out_if.out_last  = r_last;
  assign out_if.out_dir   = r_odir;

endmodule

// File: doc/a5_burst_generator.md
A5_BURST_GENERATOR -- requirements
Module: a5_burst_generator

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8 (legal 1..32), setting keystream output word width.
REQ-002 The block SHALL have parameter BURST_BITS, default 114, setting keystream bits per burst.
REQ-003 The block SHALL have parameter MIX_CYCLES, default 100, setting discarded majority-clocked cycles.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a new session.
- key  in  64  session key; bit i is loaded i-th.
- frame  in  22  frame number; bit i is loaded i-th.
- busy  out  1  session in progress.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WORD_W  keystream word; first bit is in the MSB.
- out_last  out  1  final word of a burst.
- out_dir  out  1  0 = downlink burst, 1 = uplink burst.

Function
REQ-005 The three LFSRs SHALL be configured as follows; keystream bit = XOR of the three MSBs:
- R1: 19 bits, taps 18/17/16/13, clock bit 8.
- R2: 22 bits, taps 21/20, clock bit 10.
- R3: 23 bits, taps 22/21/20/7, clock bit 10.
REQ-006 FSM states SHALL be IDLE, LOAD, MIX, GEN, DONE; reset state IDLE.
REQ-007 Start sampled high in any state SHALL do all of the following on that edge, then enter LOAD:
- clear all LFSRs, the packer and out_valid;
- latch key and frame.
REQ-008 LOAD SHALL last 64+22 cycles, clocking all LFSRs unconditionally with the next key bit, then frame bit, XORed into each feedback.
REQ-009 MIX SHALL last MIX_CYCLES majority-clocked cycles with output discarded; a register steps iff its clock bit equals the majority of the three clock bits.
REQ-010 GEN SHALL produce 2*BURST_BITS majority-clocked bits: first BURST_BITS downlink (out_dir=0), next BURST_BITS uplink (out_dir=1).
REQ-011 Bits SHALL be packed MSB-first into WORD_W words; each burst starts a fresh word.
REQ-012 A burst's final word SHALL be zero-padded in its unused low bits and SHALL carry out_last=1.
REQ-013 A completed word SHALL transfer to the output register when that register is empty or being accepted in the same cycle; otherwise the LFSRs and packer SHALL stall with no bit lost.
REQ-014 Output transfer SHALL use a valid/ready handshake: while out_valid=1 and out_ready=0, out_data, out_last and out_dir SHALL hold stable.
REQ-015 With out_ready held high, throughput SHALL be one word per WORD_W cycles, with no bubble between bursts beyond padding.
REQ-016 First out_valid SHALL rise on edge 1+86+MIX_CYCLES+WORD_W, counting the start-sampling edge as edge 1 (195 at defaults).
REQ-017 DONE SHALL be entered after the uplink last word is accepted; the FSM SHALL then return to IDLE on the next edge.
REQ-018 busy SHALL be high in LOAD, MIX, GEN and DONE.
REQ-019 Start during GEN SHALL abort the session: the pending word is dropped and no out_last is issued for the aborted burst.
REQ-020 out_ready SHALL be ignored when out_valid=0.

Reset
REQ-021 Asserting reset_n low SHALL, asynchronously and at any point, including mid-session, set the following:
- FSM IDLE;
- busy, out_valid, out_last, out_dir, out_data = 0;
- LFSRs and counters cleared.
REQ-022 After reset release, no output SHALL appear until start is sampled.

Structure
REQ-023 Package a5_pkg SHALL hold:
- LFSR lengths, tap masks and clock-bit indices;
- KEY_W=64, FRAME_W=22;
- the FSM state enum.
REQ-024 A single sub-module a5_lfsr SHALL implement one LFSR with parameters length/taps/clock bit and ports clk_en, din, msb, clk_bit; it SHALL be instantiated three times.
REQ-025 Cycle/bit counters SHALL be sized with $clog2 of their maximum counts.

Verification
REQ-026 Test vector, WORD_W=8, out_ready=1:
- stimulus: key=64'hEFCDAB8967452312, frame=22'h134, start;
- downlink bytes: 53 4E AA 58 2F E8 15 1A B6 E1 85 5A 72 8C 00 (last=1);
- uplink bytes: 24 FD 35 A3 5D 5F B6 52 6D 32 F9 06 DF 1A C0 (last=1).
REQ-027 Latency check: same stimulus -> first out_valid on edge 195; 15 words per burst; busy low after DONE.
REQ-028 Random out_ready backpressure (50%) -> identical byte sequence; out_data stable whenever valid&&!ready.
REQ-029 Start re-asserted at GEN word 5 -> output stops; new session yields a full REQ-026 sequence with first valid 195 edges later.
REQ-030 reset_n pulsed low during MIX -> all outputs 0 immediately; block idle until the next start.
REQ-031 WORD_W=32 -> downlink words 534EAA58, 2FE8151A, B6E1855A, 728C0000 (last=1); uplink begins 24FD35A3.
